// File: rtl/instr_sequencer.sv
// Program sequencer that issues 16-bit opcodes to the cores and runs NOP/HALT/SETLOOP/JUMP itself.
// Optional single-step gating is compiled in with `define SEQ_SINGLE_STEP_EN.
module instr_sequencer #(
  parameter  int NR_INSTR = 16,
  localparam int ADDR_W   = $clog2(NR_INSTR)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [15:0]       prog_data,
  input  logic              start,
  input  logic              hold,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic              step_en,
  input  logic              step,
`endif
  output logic [15:0]       opcode,
  output logic              execute,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pc_out
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [7:0]          r_loop_cnt;
  logic [15:0]         r_opcode;
  logic                r_execute;
  logic                r_busy;
  logic                r_done;
  // Set after the last address advanced, so the next run cycle is an implicit HALT.
  logic                r_end;
  logic [15:0]         r_mem [NR_INSTR];

  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   w_pc_nxt;
  logic [7:0]          w_loop_nxt;
  logic [15:0]         w_opcode_nxt;
  logic                w_exec_nxt;
  logic                w_done_nxt;
  logic                w_end_nxt;
  logic [15:0]         w_instr;
  logic                w_last;
  logic                w_adv;

`ifdef SEQ_SINGLE_STEP_EN
  assign w_adv = !hold && (!step_en || step);
`else
  assign w_adv = !hold;
`endif

  assign w_instr = r_mem[r_pc];
  assign w_last  = (r_pc == ADDR_W'(NR_INSTR - 1));

  // Program memory write port, only while idle.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && prog_we) begin
      r_mem[prog_addr] <= prog_data;
    end
  end

  // Next-state and decode of the fetched instruction.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_loop_nxt   = r_loop_cnt;
    w_opcode_nxt = r_opcode;
    w_exec_nxt   = 1'b0;
    w_done_nxt   = 1'b0;
    w_end_nxt    = r_end;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = {ADDR_W{1'b0}};
          w_end_nxt   = 1'b0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (!w_adv) begin
          w_exec_nxt = 1'b0;
        end else if (r_end) begin
          w_state_nxt = S_IDLE;
          w_pc_nxt    = {ADDR_W{1'b0}};
          w_done_nxt  = 1'b1;
          w_end_nxt   = 1'b0;
        end else begin
          case (w_instr[15:12])
            4'b1000: begin
              w_pc_nxt  = r_pc + ADDR_W'(1);
              w_end_nxt = w_last;
            end
            4'b1001: begin
              w_state_nxt = S_IDLE;
              w_pc_nxt    = {ADDR_W{1'b0}};
              w_done_nxt  = 1'b1;
              w_end_nxt   = 1'b0;
            end
            4'b1010: begin
              w_loop_nxt = w_instr[7:0];
              w_pc_nxt   = r_pc + ADDR_W'(1);
              w_end_nxt  = w_last;
            end
            4'b1011: begin
              if (r_loop_cnt != 8'd0) begin
                w_loop_nxt = r_loop_cnt - 8'd1;
                w_pc_nxt   = w_instr[ADDR_W-1:0];
              end else begin
                w_pc_nxt  = r_pc + ADDR_W'(1);
                w_end_nxt = w_last;
              end
            end
            default: begin
              w_opcode_nxt = w_instr;
              w_exec_nxt   = 1'b1;
              w_pc_nxt     = r_pc + ADDR_W'(1);
              w_end_nxt    = w_last;
            end
          endcase
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_pc_nxt    = {ADDR_W{1'b0}};
        w_end_nxt   = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= {ADDR_W{1'b0}};
      r_loop_cnt <= 8'd0;
      r_opcode   <= 16'h0000;
      r_execute  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_end      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_loop_cnt <= w_loop_nxt;
      r_opcode   <= w_opcode_nxt;
      r_execute  <= w_exec_nxt;
      r_busy     <= (w_state_nxt == S_RUN);
      r_done     <= w_done_nxt;
      r_end      <= w_end_nxt;
    end
  end

  assign opcode  = r_opcode;
  assign execute = r_execute;
  assign busy    = r_busy;
  assign done    = r_done;
  assign pc_out  = r_pc;

endmodule
